iterative_muldiv_alu: RTL

- Parametrised, multi-cycle successor to the single-cycle ALU. It executes the RV32M multiply/divide/remainder ops using a one-bit-per-cycle shift-add multiplier and a restoring divider.
- Sits beside the combinational ALU in the execute stage. The execute stage stalls on `in_ready`/`out_valid`.
- Uses the same operand/result naming as the ALU (`port_a`, `port_b`, `port_out`).
- Adds a valid/ready handshake on both sides and a flush input.

---
 rtl/iterative_muldiv_alu.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/iterative_muldiv_alu.sv
// Multi-cycle RV32M multiply/divide/remainder unit: shift-add multiplier and
// restoring divider, one bit per cycle, with valid/ready handshakes and flush.
module iterative_muldiv_alu #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] port_a,
   input  logic [WIDTH-1:0] port_b,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] port_out,
   output logic             busy,
   output logic [1:0]       state_dbg
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   // Handshakes: a transfer happens on a rising edge where valid && ready are
   // both high; out_valid and port_out hold steady until out_ready is seen.
   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIXUP = 2'd2, DONE = 2'd3} state_t;

   state_t             state, state_n;
   logic [2:0]         op_q;
   logic               neg_q;
   logic [WIDTH-1:0]   m;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   rem;
   logic [CNT_W-1:0]   cnt;

   logic               accept;
   logic               signed_div, a_signed, b_signed, a_neg, b_neg, res_neg;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic               b_zero, div_ovf, special;
   logic [WIDTH-1:0]   special_res;

   logic [WIDTH:0]     addend, sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     shifted, diff;
   logic               ge;
   logic [WIDTH-1:0]   rem_next;
   logic [2*WIDTH-1:0] full;
   logic [WIDTH-1:0]   qr, qr_f, result;
   logic               unused_diff_msb;

   assign in_ready  = (state == IDLE) && !flush;
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign state_dbg = state;
   assign accept    = in_valid && in_ready;

   // Operand conditioning and special-case detection on the raw request.
   always_comb begin
      signed_div  = op[2] && !op[0];
      a_signed    = signed_div || (op == 3'b001) || (op == 3'b010);
      b_signed    = signed_div || (op == 3'b001);
      a_neg       = a_signed && port_a[WIDTH-1];
      b_neg       = b_signed && port_b[WIDTH-1];
      res_neg     = (op == 3'b110) ? a_neg : (a_neg ^ b_neg);
      mag_a       = a_neg ? (~port_a + 1'b1) : port_a;
      mag_b       = b_neg ? (~port_b + 1'b1) : port_b;
      b_zero      = (port_b == '0);
      div_ovf     = signed_div && (port_a == {1'b1, {(WIDTH-1){1'b0}}}) && (port_b == '1);
      special     = op[2] && (b_zero || div_ovf);
      special_res = '0;
      if (b_zero)
         special_res = op[1] ? port_a : '1;
      else
         special_res = op[1] ? '0 : port_a;
   end

   // One iteration of each algorithm plus the final sign fix and word select.
   always_comb begin
      addend          = prod[0] ? {1'b0, m} : '0;
      sum             = {1'b0, prod[2*WIDTH-1:WIDTH]} + addend;
      mul_next        = {sum, prod[WIDTH-1:1]};
      shifted         = {rem, prod[WIDTH-1]};
      ge              = (shifted >= {1'b0, m});
      diff            = shifted - {1'b0, m};
      rem_next        = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      unused_diff_msb = diff[WIDTH];
      full            = neg_q ? (~prod + 1'b1) : prod;
      qr              = op_q[1] ? rem : prod[WIDTH-1:0];
      qr_f            = neg_q ? (~qr + 1'b1) : qr;
      result          = '0;
      if (op_q[2])
         result = qr_f;
      else if (op_q[1:0] == 2'b00)
         result = full[WIDTH-1:0];
      else
         result = full[2*WIDTH-1:WIDTH];
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:  if (accept) state_n = special ? DONE : CALC;
         CALC:  if (flush) state_n = IDLE;
                else if (cnt == CNT_W'(1)) state_n = FIXUP;
         FIXUP: state_n = flush ? IDLE : DONE;
         DONE:  if (flush || out_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= IDLE;
         port_out <= '0;
         cnt      <= '0;
         op_q     <= '0;
         neg_q    <= 1'b0;
         m        <= '0;
         prod     <= '0;
         rem      <= '0;
      end else begin
         state <= state_n;
         case (state)
            IDLE: if (accept) begin
               op_q  <= op;
               neg_q <= res_neg;
               cnt   <= CNT_W'(WIDTH);
               rem   <= '0;
               // Divides keep the divisor in m and the dividend in the low half.
               m     <= op[2] ? mag_b : mag_a;
               prod  <= {{WIDTH{1'b0}}, (op[2] ? mag_a : mag_b)};
               if (special) port_out <= special_res;
            end
            CALC: if (!flush) begin
               cnt <= cnt - CNT_W'(1);
               if (op_q[2]) begin
                  prod[WIDTH-1:0] <= {prod[WIDTH-2:0], ge};
                  rem             <= rem_next;
               end else begin
                  prod <= mul_next;
               end
            end
            FIXUP: if (!flush) port_out <= result;
            default: ;
         endcase
      end
   end

endmodule
